seq_alu: RTL and testbench

- Parametrised, registered successor to the 32-bit ripple ALU.
- Accepts one operation per handshake on a valid/ready input channel and returns the result plus flags on a valid/ready output channel.
- Single-cycle logic/add/sub ops complete with 1-cycle latency; optional iterative multiply takes WIDTH cycles.
- Sits between the decode stage and writeback in the multi-cycle datapath.

---
 rtl/seq_alu.sv | 143 ++++++++++++++
 tb/tb_seq_alu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both the operation and result channels.
// Define ALU_MUL_EN to build the iterative unsigned shift-add multiplier (WIDTH cycles).
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             carry_out,
  output logic             zero,
  output logic             negative
);

  localparam logic [2:0] OpMul = 3'b000;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpNor = 3'b110;
  localparam logic [2:0] OpXor = 3'b111;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StDone = 2'd2} state_e;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StDone = 2'd2} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic             overflow_q, carry_q, zero_q, negative_q;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] res;
  logic             res_ovf, res_cry;

  // Gating with reset keeps in_ready low for the whole time reset is held.
  assign in_ready  = reset & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

  // SUB reuses the adder as A + ~B + 1, so carry out doubles as the no-borrow flag.
  always_comb begin
    b_eff   = (control == OpSub) ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (control == OpSub)};
    add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
    res     = '0;
    res_ovf = 1'b0;
    res_cry = 1'b0;
    case (control)
      OpAdd, OpSub: begin
        res     = sum[WIDTH-1:0];
        res_ovf = add_ovf;
        res_cry = sum[WIDTH];
      end
      OpAnd:   res = A & B;
      OpOr:    res = A | B;
      OpNor:   res = ~(A | B);
      OpXor:   res = A ^ B;
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      out_q      <= '0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_MUL_EN
      if (control == OpMul) begin
        mcand_q  <= {{WIDTH{1'b0}}, A};
        mplier_q <= B;
        acc_q    <= '0;
        cnt_q    <= CntW'(WIDTH);
        state_q  <= StBusy;
      end else
`endif
      begin
        out_q      <= res;
        overflow_q <= res_ovf;
        carry_q    <= res_cry;
        zero_q     <= (res == '0);
        negative_q <= res[WIDTH-1];
        state_q    <= StDone;
      end
    end else if ((state_q == StDone) && out_ready) begin
      state_q <= StIdle;
`ifdef ALU_MUL_EN
    end else if (state_q == StBusy) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      // Last step: the adder output already holds the full product.
      if (cnt_q == CntW'(1)) begin
        out_q      <= acc_nxt[WIDTH-1:0];
        overflow_q <= |acc_nxt[2*WIDTH-1:WIDTH];
        carry_q    <= 1'b0;
        zero_q     <= (acc_nxt[WIDTH-1:0] == '0);
        negative_q <= acc_nxt[WIDTH-1];
        state_q    <= StDone;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); MUL checks follow ALU_MUL_EN.
module tb_seq_alu;

  localparam int unsigned W = 32;

  localparam logic [2:0] OpMul  = 3'b000;
  localparam logic [2:0] OpRsvd = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpNor  = 3'b110;
  localparam logic [2:0] OpXor  = 3'b111;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         overflow, carry_out, zero, negative;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (res),
    .overflow  (overflow),
    .carry_out (carry_out),
    .zero      (zero),
    .negative  (negative)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one edge, then scramble the operands to prove they were captured.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    control  = op;
    a        = a_v;
    b        = b_v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = ~a_v;
    b        = ~b_v;
    control  = OpAnd;
  endtask

  // exp_flags = {overflow, carry_out, zero, negative}
  task automatic check_res(input string tag, input logic [W-1:0] exp_out,
                           input logic [3:0] exp_flags);
    check_eq({tag, ".valid"}, W'(out_valid), W'(1'b1));
    check_eq({tag, ".out"}, res, exp_out);
    check_eq({tag, ".flags"}, W'({overflow, carry_out, zero, negative}), W'(exp_flags));
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, ".valid"}, W'(out_valid), '0);
    check_eq({tag, ".out"}, res, '0);
    check_eq({tag, ".flags"}, W'({overflow, carry_out, zero, negative}), '0);
    check_eq({tag, ".rdy_low"}, W'(in_ready), '0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq({tag, ".rdy_after"}, W'(in_ready), W'(1'b1));
  endtask

  // Steps until out_valid; checks latency and that in_ready stayed low meanwhile.
  task automatic wait_result(input string tag, input int unsigned exp_lat);
    int unsigned lat = 0;
    logic        rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      rdy_seen |= in_ready;
      step();
      lat++;
    end
    check_eq({tag, ".lat"}, W'(lat), W'(exp_lat));
    check_eq({tag, ".busy_rdy"}, W'(rdy_seen), '0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    control   = OpAdd;
    step();
    step();
    check_cleared("rst");
    release_reset("rst");
    out_ready = 1'b1;

    issue(OpAdd, 32'h7FFF_FFFF, 32'h0000_0001);
    check_res("add_ovf", 32'h8000_0000, 4'b1001);
    step();
    check_eq("drain.valid", W'(out_valid), '0);

    issue(OpSub, 32'd5, 32'd5);
    check_res("sub_eq", 32'h0, 4'b0110);
    issue(OpSub, 32'd0, 32'd1);
    check_res("sub_borrow", 32'hFFFF_FFFF, 4'b0001);
    issue(OpSub, 32'h8000_0000, 32'd1);
    check_res("sub_ovf", 32'h7FFF_FFFF, 4'b1100);

    // Back-to-back: one result per cycle.
    issue(OpAdd, 32'd1, 32'd2);
    check_res("b2b0", 32'd3, 4'b0000);
    issue(OpAdd, 32'd3, 32'd4);
    check_res("b2b1", 32'd7, 4'b0000);
    issue(OpAdd, 32'hFFFF_FFFF, 32'd1);
    check_res("b2b2", 32'h0, 4'b0110);
    issue(OpAdd, 32'h8000_0000, 32'h8000_0000);
    check_res("b2b3", 32'h0, 4'b1110);
    step();
    check_eq("b2b.drain", W'(out_valid), '0);

    // Backpressure then simultaneous drain + accept.
    out_ready = 1'b0;
    issue(OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_res("and", 32'hF000_F000, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step();
      check_res("hold", 32'hF000_F000, 4'b0001);
      check_eq("hold.rdy", W'(in_ready), '0);
    end
    control   = OpXor;
    a         = 32'h0000_1234;
    b         = 32'h0000_1234;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("xor.rdy", W'(in_ready), W'(1'b1));
    step();
    in_valid = 1'b0;
    check_res("xor", 32'h0, 4'b0010);

    issue(OpOr, 32'h0000_FFFF, 32'hFFFF_0000);
    check_res("or", 32'hFFFF_FFFF, 4'b0001);
    issue(OpNor, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    check_res("nor0", 32'h0, 4'b0010);
    issue(OpNor, 32'h0, 32'h0);
    check_res("nor1", 32'hFFFF_FFFF, 4'b0001);
    issue(OpRsvd, 32'd5, 32'd7);
    wait_result("rsvd", 0);
    check_res("rsvd", 32'h0, 4'b0010);

`ifdef ALU_MUL_EN
    issue(OpMul, 32'd13, 32'd11);
    wait_result("mul13x11", W);
    check_res("mul13x11", 32'h8F, 4'b0000);
    issue(OpMul, 32'h0001_0000, 32'h0001_0000);
    wait_result("mul_ovf", W);
    check_res("mul_ovf", 32'h0, 4'b1010);

    // Abort mid-BUSY: the counter and accumulator must restart cleanly.
    issue(OpMul, 32'd13, 32'd11);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    #2;
    check_cleared("rst_busy");
    release_reset("rst_busy");
    step();
    check_eq("rst_busy.no_result", W'(out_valid), '0);
    issue(OpMul, 32'd3, 32'd5);
    wait_result("mul3x5", W);
    check_res("mul3x5", 32'd15, 4'b0000);
`else
    issue(OpMul, 32'd3, 32'd3);
    wait_result("mul_off", 0);
    check_res("mul_off", 32'h0, 4'b0010);
`endif
    step();

    // Abort mid-DONE: pending result is discarded.
    out_ready = 1'b0;
    issue(OpAdd, 32'd1, 32'd1);
    check_res("pend", 32'd2, 4'b0000);
    reset = 1'b0;
    #2;
    check_cleared("rst_done");
    release_reset("rst_done");
    step();
    check_eq("rst_done.no_result", W'(out_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
